// File: rtl/vga_pkg.sv
// Shared VGA/game constants and types used by the obstacle control and draw stages.
// Obstacle geometry lives here so draw_obstacle and obstacle_ctl agree on width and gap.
package vga_pkg;

  localparam int HOR_PIXELS = 800;
  localparam int VER_PIXELS = 600;

  // Obstacle geometry shared with draw_obstacle
  localparam int OBST_W      = 50;
  localparam int GAP         = 150;
  localparam int GAP_TOP_MIN = 100;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } obst_state_t;

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left with feedback into bit 0.
// Free-running; reusable by any randomised game object.
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] value
);

  logic [15:0] lfsr_reg;
  logic        feedback;

  assign feedback = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[14:0], feedback};
    end
  end

  assign value = lfsr_reg;

endmodule

// File: rtl/obstacle_ctl.sv
// Obstacle game logic: scrolls the pipe pair once per frame, respawns it with a random
// gap, freezes on collision and counts obstacles passed by the player.
module obstacle_ctl
  import vga_pkg::*;
#(
  parameter int          X_START     = HOR_PIXELS,
  parameter int          OBST_WIDTH  = OBST_W,
  parameter int          GAP_H       = GAP,
  parameter int          GAP_MIN     = GAP_TOP_MIN,
  parameter int          PLAYER_X    = 100,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int          SCORE_MAX   = 999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        start,
  input  logic        collide,
  input  logic [3:0]  speed,
  output logic [11:0] obstacle_xpos_1,
  output logic [11:0] obstacle_ypos_1,
  output logic [11:0] obstacle_ypos_2,
  output logic        score_pulse,
  output logic [9:0]  score,
  output logic        running
);

  localparam logic [11:0] X_START_12  = 12'(X_START);
  localparam logic [11:0] OBST_W_12   = 12'(OBST_WIDTH);
  localparam logic [11:0] GAP_12      = 12'(GAP_H);
  localparam logic [11:0] GAP_MIN_12  = 12'(GAP_MIN);
  localparam logic [11:0] PLAYER_X_12 = 12'(PLAYER_X);
  localparam logic [9:0]  SCORE_MAX_10 = 10'(SCORE_MAX);

  logic [15:0] lfsr;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .value (lfsr)
  );

  obst_state_t state_reg, state_next;
  logic [11:0] xpos_reg, xpos_next;
  logic [11:0] ypos_1_reg, ypos_1_next;
  logic [11:0] ypos_2_reg, ypos_2_next;
  logic [9:0]  score_reg, score_next;
  logic        score_pulse_reg, score_pulse_next;
  logic        running_reg, running_next;
  logic [3:0]  speed_q_reg, speed_q_next;
  logic        vblnk_d_reg;

  logic        tick;
  logic [11:0] speed_ext;
  logic [11:0] load_y1;
  logic [11:0] load_y2;
  logic [11:0] xpos_moved;
  logic        at_left_edge;
  logic        passed;

  assign tick      = vblnk & ~vblnk_d_reg;
  assign speed_ext = {8'd0, speed_q_reg};

  // Both gap edges come from the same LFSR sample so the gap height is always exact
  assign load_y1 = GAP_MIN_12 + {4'd0, lfsr[7:0]};
  assign load_y2 = load_y1 + GAP_12;

  assign at_left_edge = (xpos_reg <= speed_ext);
  assign xpos_moved   = xpos_reg - speed_ext;
  assign passed       = ((xpos_reg + OBST_W_12) >= PLAYER_X_12) &&
                        ((xpos_moved + OBST_W_12) < PLAYER_X_12);

  always_comb begin
    state_next       = state_reg;
    xpos_next        = xpos_reg;
    ypos_1_next      = ypos_1_reg;
    ypos_2_next      = ypos_2_reg;
    score_next       = score_reg;
    score_pulse_next = 1'b0;
    speed_q_next     = speed_q_reg;

    case (state_reg)
      IDLE, FROZEN: begin
        if (start) begin
          state_next   = RUN;
          xpos_next    = X_START_12;
          ypos_1_next  = load_y1;
          ypos_2_next  = load_y2;
          score_next   = 10'd0;
          speed_q_next = (speed == 4'd0) ? 4'd1 : speed;
        end
      end
      RUN: begin
        // Collision wins over a same-cycle tick so the frozen frame shows the hit position
        if (collide) begin
          state_next = FROZEN;
        end else if (tick) begin
          if (at_left_edge) begin
            xpos_next   = X_START_12;
            ypos_1_next = load_y1;
            ypos_2_next = load_y2;
          end else begin
            xpos_next = xpos_moved;
            if (passed) begin
              score_pulse_next = 1'b1;
              if (score_reg < SCORE_MAX_10) begin
                score_next = score_reg + 10'd1;
              end
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase

    running_next = (state_next == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      xpos_reg        <= X_START_12;
      ypos_1_reg      <= GAP_MIN_12;
      ypos_2_reg      <= GAP_MIN_12 + GAP_12;
      score_reg       <= 10'd0;
      score_pulse_reg <= 1'b0;
      running_reg     <= 1'b0;
      speed_q_reg     <= 4'd1;
      vblnk_d_reg     <= 1'b0;
    end else begin
      state_reg       <= state_next;
      xpos_reg        <= xpos_next;
      ypos_1_reg      <= ypos_1_next;
      ypos_2_reg      <= ypos_2_next;
      score_reg       <= score_next;
      score_pulse_reg <= score_pulse_next;
      running_reg     <= running_next;
      speed_q_reg     <= speed_q_next;
      vblnk_d_reg     <= vblnk;
    end
  end

  assign obstacle_xpos_1 = xpos_reg;
  assign obstacle_ypos_1 = ypos_1_reg;
  assign obstacle_ypos_2 = ypos_2_reg;
  assign score_pulse     = score_pulse_reg;
  assign score           = score_reg;
  assign running         = running_reg;

endmodule

// File: tb/tb_obstacle_ctl.sv
// Directed bench for obstacle_ctl: reset, scrolling, respawn, scoring, collision freeze,
// speed latching, plus a small-saturation instance for the score limit.
module tb_obstacle_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        start;
  logic        start_sat;
  logic        collide;
  logic [3:0]  speed;

  logic [11:0] xpos, ypos_1, ypos_2;
  logic        score_pulse, running;
  logic [9:0]  score;

  logic [11:0] xpos_sat, ypos_1_sat, ypos_2_sat;
  logic        score_pulse_sat, running_sat;
  logic [9:0]  score_sat;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_lfsr, m_prev;
  logic [15:0] tick_lfsr;
  logic        pulse_seen, pulse_after, pulse_seen_sat;
  int          pulse_cnt_sat;
  int          exp_y1;

  always #5 clk = ~clk;

  obstacle_ctl dut (
    .clk             (clk),
    .rst             (rst),
    .vblnk           (vblnk),
    .start           (start),
    .collide         (collide),
    .speed           (speed),
    .obstacle_xpos_1 (xpos),
    .obstacle_ypos_1 (ypos_1),
    .obstacle_ypos_2 (ypos_2),
    .score_pulse     (score_pulse),
    .score           (score),
    .running         (running)
  );

  // Short track and a tiny score limit so saturation is reachable in a few passes
  obstacle_ctl #(
    .X_START   (160),
    .SCORE_MAX (2)
  ) dut_sat (
    .clk             (clk),
    .rst             (rst),
    .vblnk           (vblnk),
    .start           (start_sat),
    .collide         (1'b0),
    .speed           (speed),
    .obstacle_xpos_1 (xpos_sat),
    .obstacle_ypos_1 (ypos_1_sat),
    .obstacle_ypos_2 (ypos_2_sat),
    .score_pulse     (score_pulse_sat),
    .score           (score_sat),
    .running         (running_sat)
  );

  // Reference LFSR; m_prev is the value the DUT sampled at the most recent edge
  always @(posedge clk) begin
    if (rst) m_lfsr <= 16'hACE1;
    else     m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_prev <= m_lfsr;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("ok   %s: %0d", tag, got);
    end
  endtask

  task automatic do_tick(input bit hit);
    vblnk   = 1'b1;
    collide = hit;
    @(posedge clk); #1;
    tick_lfsr      = m_prev;
    pulse_seen     = score_pulse;
    pulse_seen_sat = score_pulse_sat;
    vblnk   = 1'b0;
    collide = 1'b0;
    @(posedge clk); #1;
    pulse_after   = score_pulse;
    pulse_cnt_sat += int'(pulse_seen_sat);
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1'b0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    tick_lfsr = m_prev;
    start = 1'b0;
  endtask

  task automatic pulse_start_sat();
    start_sat = 1'b1;
    @(posedge clk); #1;
    tick_lfsr = m_prev;
    start_sat = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; vblnk = 1'b0; start = 1'b0; start_sat = 1'b0;
    collide = 1'b0; speed = 4'd2; pulse_cnt_sat = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Reset values
    chk("rst_xpos", int'(xpos), 800);
    chk("rst_ypos1", int'(ypos_1), 100);
    chk("rst_ypos2", int'(ypos_2), 250);
    chk("rst_score", int'(score), 0);
    chk("rst_running", int'(running), 0);
    chk("rst_pulse", int'(score_pulse), 0);

    // Frames in IDLE change nothing
    do_ticks(3);
    chk("idle_xpos", int'(xpos), 800);
    chk("idle_ypos1", int'(ypos_1), 100);
    chk("idle_running", int'(running), 0);

    // Start at speed 2
    speed = 4'd2;
    pulse_start();
    exp_y1 = 100 + int'(tick_lfsr[7:0]);
    chk("start_running", int'(running), 1);
    chk("start_xpos", int'(xpos), 800);
    chk("start_ypos1", int'(ypos_1), exp_y1);
    chk("start_ypos2", int'(ypos_2), exp_y1 + 150);
    do_tick(1'b0); chk("move_798", int'(xpos), 798);
    do_tick(1'b0); chk("move_796", int'(xpos), 796);
    do_tick(1'b0); chk("move_794", int'(xpos), 794);
    chk("gap_height", int'(ypos_2) - int'(ypos_1), 150);
    chk("ypos1_in_range", int'(ypos_1 >= 12'd100 && ypos_1 <= 12'd355), 1);

    // start during RUN is ignored, speed stays 2
    speed = 4'd5;
    pulse_start();
    chk("run_start_ign_x", int'(xpos), 794);
    do_tick(1'b0); chk("run_speed_kept", int'(xpos), 792);

    // Scroll to x=2; the pass at 50->48 scores once
    do_ticks(395);
    chk("reach_x2", int'(xpos), 2);
    chk("score_after_pass", int'(score), 1);

    // Respawn from x=2 at speed 2
    do_tick(1'b0);
    exp_y1 = 100 + int'(tick_lfsr[7:0]);
    chk("respawn_xpos", int'(xpos), 800);
    chk("respawn_ypos1", int'(ypos_1), exp_y1);
    chk("respawn_ypos2", int'(ypos_2), exp_y1 + 150);
    chk("respawn_no_pulse", int'(pulse_seen), 0);

    // Collision together with a tick freezes without moving
    do_tick(1'b0); chk("pre_hit_x", int'(xpos), 798);
    do_tick(1'b1);
    chk("hit_xpos", int'(xpos), 798);
    chk("hit_running", int'(running), 0);
    do_tick(1'b0); do_tick(1'b1);
    chk("frozen_xpos", int'(xpos), 798);
    chk("frozen_score", int'(score), 1);

    // Restart with speed 0 -> 1 px per frame, score cleared
    speed = 4'd0;
    pulse_start();
    exp_y1 = 100 + int'(tick_lfsr[7:0]);
    chk("restart_xpos", int'(xpos), 800);
    chk("restart_score", int'(score), 0);
    chk("restart_running", int'(running), 1);
    chk("restart_ypos1", int'(ypos_1), exp_y1);
    speed = 4'd7;
    do_tick(1'b0); chk("speed0_799", int'(xpos), 799);
    do_ticks(749);
    chk("reach_x50", int'(xpos), 50);
    chk("score_before_pass", int'(score), 0);

    // 50 -> 49: 49+50 < 100 scores exactly once
    do_tick(1'b0);
    chk("pass_xpos", int'(xpos), 49);
    chk("pass_pulse", int'(pulse_seen), 1);
    chk("pass_pulse_drop", int'(pulse_after), 0);
    chk("pass_score", int'(score), 1);
    do_tick(1'b0);
    chk("next_xpos", int'(xpos), 48);
    chk("next_no_pulse", int'(pulse_seen), 0);
    chk("next_score", int'(score), 1);

    // Saturating instance, speed 3 from 160: reaches x=1, pass at 52->49
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    speed = 4'd3;
    pulse_start_sat();
    pulse_cnt_sat = 0;
    chk("sat_start_x", int'(xpos_sat), 160);
    do_ticks(53);
    chk("sat_reach_x1", int'(xpos_sat), 1);
    chk("sat_score1", int'(score_sat), 1);
    do_tick(1'b0);
    exp_y1 = 100 + int'(tick_lfsr[7:0]);
    chk("sat_respawn_x", int'(xpos_sat), 160);
    chk("sat_respawn_y1", int'(ypos_1_sat), exp_y1);
    chk("sat_respawn_y2", int'(ypos_2_sat), exp_y1 + 150);
    do_ticks(54);
    chk("sat_score2", int'(score_sat), 2);
    do_ticks(37);
    chk("sat_third_x", int'(xpos_sat), 49);
    chk("sat_third_pulse", int'(pulse_seen_sat), 1);
    chk("sat_score_held", int'(score_sat), 2);
    chk("sat_pulse_count", pulse_cnt_sat, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/obstacle_ctl.md
Name: obstacle_ctl

Overview:
Upstream game-logic stage for draw_obstacle. It generates obstacle_xpos_1, obstacle_ypos_1 (bottom edge of the top pipe) and obstacle_ypos_2 (top edge of the bottom pipe).
- The obstacle scrolls left once per video frame and respawns at the right edge with a pseudo-random gap.
- A small state machine handles start and collision-freeze.
- The block counts obstacles passed by the player.

Parameters:
- X_START, 800, respawn/reset x position; default equals HOR_PIXELS, i.e. offscreen right.
- OBST_W, 50, obstacle width in pixels; matches the draw stage.
- GAP, 150, vertical gap height; ypos_2 = ypos_1 + GAP.
- GAP_TOP_MIN, 100, minimum ypos_1. Constraint: GAP_TOP_MIN + 255 + GAP < VER_PIXELS.
- PLAYER_X, 100, x coordinate of the player's left edge, used for scoring.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- SCORE_MAX, 999, saturation value of the score counter.

Ports:
- clk, in, 1, system clock (pixel clock domain).
- rst, in, 1, reset: synchronous, active-high.
- vblnk, in, 1, vertical blank from the timing stage; its rising edge is the frame tick.
- start, in, 1, single-cycle start/restart request.
- collide, in, 1, level or pulse collision indication from the collision checker.
- speed, in, 4, pixels moved per frame. Latched on start; a value of 0 is treated as 1.
- obstacle_xpos_1, out, 12, left x of the obstacle.
- obstacle_ypos_1, out, 12, last row of the top pipe.
- obstacle_ypos_2, out, 12, first row of the bottom pipe.
- score_pulse, out, 1, one-cycle pulse when an obstacle is passed.
- score, out, 10, saturating count of obstacles passed.
- running, out, 1, high while in state RUN.

Behaviour:
- Reset values:
  - xpos = X_START; ypos_1 = GAP_TOP_MIN; ypos_2 = GAP_TOP_MIN + GAP.
  - score = 0; score_pulse = 0; running = 0.
  - state = IDLE; lfsr = LFSR_SEED; vblnk_d = 0; speed_q = 1.
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Shift-left form: new bit = b15^b13^b12^b10, inserted at b0.
  - Advances every clk cycle when not in reset, in all states.
- Frame tick:
  - tick = vblnk & ~vblnk_d (combinational); vblnk_d is registered every cycle.
  - Exactly one tick per frame.
- Respawn (load) operation:
  - xpos = X_START.
  - ypos_1 = GAP_TOP_MIN + lfsr[7:0], using the current lfsr value.
  - ypos_2 = ypos_1 + GAP, computed from the same lfsr sample in the same cycle.
- State machine:
  - IDLE:
    - Outputs hold their reset values.
    - start: perform a load, score = 0, latch speed_q, go to RUN.
  - RUN:
    - collide (highest priority): go to FROZEN; positions are not updated that cycle even if tick is high.
    - Else on tick with xpos <= speed_q: perform a load (respawn). No negative or underflowed x is ever produced.
    - Else on tick: xpos = xpos - speed_q.
    - start is ignored in RUN.
  - FROZEN:
    - All positions and score hold.
    - start behaves exactly as in IDLE.
    - collide is ignored.
- Scoring:
  - Occurs on a RUN tick that moves (not respawns) the obstacle, when (xpos_old + OBST_W >= PLAYER_X) && (xpos_new + OBST_W < PLAYER_X).
  - Effect: score_pulse = 1 for that one cycle and score = min(score+1, SCORE_MAX). At SCORE_MAX the pulse still fires and the count holds.
  - score_pulse is 0 in every other cycle.
- running = (state == RUN), registered.
- Latency: positions change on the clk edge at which tick is high, so draw_obstacle sees new values from the next cycle, which falls inside vertical blank. There is no mid-frame tearing.
- Arithmetic:
  - 12-bit unsigned throughout; the GAP sum fits by the parameter constraint.
  - The compare xpos <= speed_q zero-extends speed_q.
- Reset mid-operation returns to IDLE with all reset values regardless of the current state or tick.

Decomposition:
- vga_pkg additions:
  - obst_state_t enum {IDLE, RUN, FROZEN}.
  - Constants OBST_W, GAP, GAP_TOP_MIN, shared with draw_obstacle in place of its literal 49.
  - Existing HOR_PIXELS and VER_PIXELS.
- Sub-module lfsr16:
  - Ports: clk, rst, seed parameter, 16-bit value out.
  - Reusable for other randomised game objects.

Test Plan:
- Reset: assert rst for 2 cycles → xpos=800, ypos_1=100, ypos_2=250, score=0, running=0. Toggling vblnk for 3 frames in IDLE changes nothing.
- Start with speed=2, then 3 vblnk rising edges → running=1, xpos 800→798→796→794. ypos_2-ypos_1=150 and ypos_1 is within [100,355].
- Respawn: run until xpos=2 with speed=2, then one tick → xpos=800, new ypos_1 matches the reference-model LFSR value +100, ypos_2=ypos_1+150. Repeat with speed=3 at xpos=1 → respawn.
- Scoring: speed=1 from xpos=50; tick → xpos=49 (49+50 = 99 < 100) → one-cycle score_pulse, score=1. The next tick produces no pulse. Preload score near 999 → score saturates at 999 while the pulse still fires.
- Collision: collide asserted in the same cycle as a tick → xpos unchanged, state FROZEN, running=0. Further ticks hold. start → xpos=800, score=0, RUN.
- Speed 0 latched at start → movement of 1 px/frame. start pulses during RUN are ignored and speed_q is unchanged.
